// File: rtl/reg_bank_pkg.sv
// Shared defaults and types for the general register bank.
package reg_bank_pkg;
  localparam int WIDTH_DEF = 16;
  localparam int NREGS_DEF = 8;
  localparam int PC_INDEX  = 7;
  localparam int IDX_W     = $clog2(NREGS_DEF);

  typedef logic [IDX_W-1:0] reg_idx_t;
endpackage

// File: rtl/reg_bank_onehot_check.sv
// Classifies a strobe vector as empty, one-hot or multi-hot and encodes the set position.
module onehot_check
  import reg_bank_pkg::*;
#(
  parameter int N  = NREGS_DEF,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_vec,
  output logic [IW-1:0] o_index,
  output logic          o_is_one,
  output logic          o_is_multi
);

  logic w_multi;

  // Clearing the lowest set bit leaves something only when two or more bits are set.
  assign w_multi    = |(i_vec & (i_vec - N'(1)));
  assign o_is_multi = w_multi;
  assign o_is_one   = (|i_vec) & ~w_multi;

  // OR-encoding is exact for one-hot input; callers ignore o_index otherwise.
  always_comb begin
    o_index = '0;
    for (int i = 0; i < N; i++) begin
      o_index = o_index | (i_vec[i] ? IW'(i) : IW'(0));
    end
  end

endmodule

// File: rtl/reg_bank.sv
// Eight-entry register bank driven by one-hot load/output-enable strobes; r7 is the PC.
module reg_bank
  import reg_bank_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREGS = NREGS_DEF
) (
  input  logic             clk,
  input  logic             nReset,
  input  logic [NREGS-1:0] regOes,
  input  logic [NREGS-1:0] regLoads,
  input  logic [WIDTH-1:0] dataIn,
  input  logic             pcInc,
  input  logic             errClear,
  output logic [WIDTH-1:0] dataOut,
  output logic             dataOutValid,
  output logic [WIDTH-1:0] pcOut,
  output logic             selError
);

  logic [WIDTH-1:0] r_regs [NREGS];
  logic             r_sel_error;

  reg_idx_t         w_oe_idx;
  logic             w_oe_one;
  logic             w_oe_multi;
  reg_idx_t         w_ld_idx;
  logic             w_ld_one;
  logic             w_ld_multi;
  logic [WIDTH-1:0] w_data_out;

  onehot_check #(.N(NREGS), .IW(IDX_W)) u_oe_check (
    .i_vec      (regOes),
    .o_index    (w_oe_idx),
    .o_is_one   (w_oe_one),
    .o_is_multi (w_oe_multi)
  );

  onehot_check #(.N(NREGS), .IW(IDX_W)) u_ld_check (
    .i_vec      (regLoads),
    .o_index    (w_ld_idx),
    .o_is_one   (w_ld_one),
    .o_is_multi (w_ld_multi)
  );

  // Register array: a one-hot load beats the PC increment; multi-hot loads write nothing.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      for (int i = 0; i < NREGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NREGS; i++) begin
        if (w_ld_one && (w_ld_idx == reg_idx_t'(i))) begin
          r_regs[i] <= dataIn;
        end else if ((i == PC_INDEX) && pcInc) begin
          r_regs[i] <= r_regs[i] + WIDTH'(1);
        end else begin
          r_regs[i] <= r_regs[i];
        end
      end
    end
  end

  // Sticky strobe-contract error; a new violation outranks a same-cycle clear.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_sel_error <= 1'b0;
    end else if (w_oe_multi || w_ld_multi) begin
      r_sel_error <= 1'b1;
    end else if (errClear) begin
      r_sel_error <= 1'b0;
    end else begin
      r_sel_error <= r_sel_error;
    end
  end

  // Combinational read mux with no write bypass.
  always_comb begin
    w_data_out = '0;
    if (w_oe_one) begin
      w_data_out = r_regs[w_oe_idx];
    end else begin
      w_data_out = '0;
    end
  end

  assign dataOut      = w_data_out;
  assign dataOutValid = w_oe_one;
  assign pcOut        = r_regs[PC_INDEX];
  assign selError     = r_sel_error;

endmodule
